// File: rtl/i2s_pkg.sv
// i2s_pkg: state encoding, shared slot geometry and slot-word builder for the I2S controllers
//   I2S_DATA_W / I2S_SLOT_W : defaults shared with the bclk/wclk clock generator
//   i2s_state_t             : IDLE / SYNC / RUN sequencer states
//   slot_word()             : left-justifies a sample inside a slot, padding the low bits with zero
package i2s_pkg;
  localparam int I2S_DATA_W = 24;
  localparam int I2S_SLOT_W = 32;
  localparam int I2S_MAX_W = 64;
  typedef enum logic [1:0] {IDLE = 2'd0, SYNC = 2'd1, RUN = 2'd2} i2s_state_t;
  function automatic logic [I2S_MAX_W-1:0] slot_word(input logic [I2S_MAX_W-1:0] d, input int data_w,
                                                     input int slot_w);
    logic [I2S_MAX_W-1:0] m;
    m = (64'd1 << data_w) - 64'd1;
    return (d & m) << (slot_w - data_w);
  endfunction
endpackage

// File: rtl/i2s_tx_ctrl_if.sv
// i2s_tx_ctrl_if: stereo sample-pair valid/ready handshake
//   s_valid : pair offered (master)
//   s_ready : holding register empty (slave)
//   s_left  : left sample, two's complement (master)
//   s_right : right sample (master)
interface i2s_tx_ctrl_if import i2s_pkg::*; #(parameter int DATA_W = I2S_DATA_W);
  logic s_valid;
  logic s_ready;
  logic [DATA_W-1:0] s_left;
  logic [DATA_W-1:0] s_right;
  modport master (output s_valid, s_left, s_right, input s_ready);
  modport slave (input s_valid, s_left, s_right, output s_ready);
endinterface

// File: rtl/i2s_clk_edge.sv
// i2s_clk_edge: registers bclk/wclk in the adc_clk domain and strobes bclk-fall and word-clock edges
//   adc_clk, adc_rst_n : system clock, asynchronous active-low reset
//   i2s_bclk, i2s_wclk : bit and word clock from the clock generator
//   fall               : bclk falling edge seen this cycle
//   wfall, wrise       : word-clock falling / rising edge, qualified by fall
module i2s_clk_edge (
  input  logic adc_clk,
  input  logic adc_rst_n,
  input  logic i2s_bclk,
  input  logic i2s_wclk,
  output logic fall,
  output logic wfall,
  output logic wrise
);
  logic bclk_q;
  logic wclk_q;
  always_ff @(posedge adc_clk or negedge adc_rst_n) begin
    if (!adc_rst_n) begin
      bclk_q <= 1'b0;
      wclk_q <= 1'b0;
    end else begin
      bclk_q <= i2s_bclk;
      if (fall) wclk_q <= i2s_wclk;
    end
  end
  // wclk is only sampled at bclk falls, so its edges line up with the shift strobe
  assign fall = bclk_q && !i2s_bclk;
  assign wfall = fall && wclk_q && !i2s_wclk;
  assign wrise = fall && !wclk_q && i2s_wclk;
endmodule

// File: rtl/i2s_tx_ctrl.sv
// i2s_tx_ctrl: double-buffered I2S transmit sequencer, serialises stereo pairs MSB first
//   adc_clk, adc_rst_n : system clock, asynchronous active-low reset
//   i2s_bclk, i2s_wclk : clock generator outputs (wclk 0 = left, 1 = right)
//   enable             : run level; dropping it stops at the end of the current frame
//   s                  : sample-pair handshake (slave side)
//   i2s_sdata          : serial data, changes on bclk falls
//   busy               : sequencer not idle
//   underrun           : one-cycle pulse when a frame starts with nothing held
//   underrun_cnt       : saturating underrun count, cleared only by reset
module i2s_tx_ctrl import i2s_pkg::*; #(
  parameter int DATA_W = I2S_DATA_W,
  parameter int SLOT_W = I2S_SLOT_W,
  parameter int CNT_W = 16
) (
  input  logic              adc_clk,
  input  logic              adc_rst_n,
  input  logic              i2s_bclk,
  input  logic              i2s_wclk,
  input  logic              enable,
  i2s_tx_ctrl_if.slave      s,
  output logic              i2s_sdata,
  output logic              busy,
  output logic              underrun,
  output logic [CNT_W-1:0]  underrun_cnt
);
  i2s_state_t state;
  logic [SLOT_W-1:0] shreg;
  logic [DATA_W-1:0] hold_l;
  logic [DATA_W-1:0] hold_r;
  logic [DATA_W-1:0] right_reg;
  logic hold_full;
  logic fall;
  logic wfall;
  logic wrise;
  logic accept;
  logic load;
  logic stop;
  logic [I2S_MAX_W-1:0] left_slot;
  logic [I2S_MAX_W-1:0] right_slot;
  logic unused_slot_hi;
  i2s_clk_edge u_edge (
    .adc_clk   (adc_clk),
    .adc_rst_n (adc_rst_n),
    .i2s_bclk  (i2s_bclk),
    .i2s_wclk  (i2s_wclk),
    .fall      (fall),
    .wfall     (wfall),
    .wrise     (wrise)
  );
  assign s.s_ready = !hold_full;
  assign accept = s.s_valid && !hold_full;
  assign busy = state != IDLE;
  // a frame is loaded at every enabled wfall once synchronised; a disabled wfall in RUN ends the stream
  assign load = wfall && enable && state != IDLE;
  assign stop = wfall && !enable && state == RUN;
  always_comb begin
    left_slot = slot_word(I2S_MAX_W'(hold_l), DATA_W, SLOT_W);
    right_slot = slot_word(I2S_MAX_W'(right_reg), DATA_W, SLOT_W);
    unused_slot_hi = ^{left_slot[I2S_MAX_W-1:SLOT_W], right_slot[I2S_MAX_W-1:SLOT_W]};
  end
  always_ff @(posedge adc_clk or negedge adc_rst_n) begin
    if (!adc_rst_n) begin
      state <= IDLE;
      shreg <= '0;
      hold_l <= '0;
      hold_r <= '0;
      right_reg <= '0;
      hold_full <= 1'b0;
      i2s_sdata <= 1'b0;
      underrun <= 1'b0;
      underrun_cnt <= '0;
    end else begin
      underrun <= 1'b0;
      // accept only happens while empty and the frame load only drains while full, so they never collide
      if (accept) begin
        hold_l <= s.s_left;
        hold_r <= s.s_right;
        hold_full <= 1'b1;
      end
      case (state)
        IDLE: begin
          i2s_sdata <= 1'b0;
          if (enable) state <= SYNC;
        end
        SYNC: begin
          i2s_sdata <= 1'b0;
          if (!enable) state <= IDLE;
        end
        RUN: begin
          if (fall) i2s_sdata <= stop ? 1'b0 : shreg[SLOT_W-1];
          if (stop) state <= IDLE;
          else if (wrise) shreg <= right_slot[SLOT_W-1:0];
          else if (fall && !wfall) shreg <= shreg << 1;
        end
        default: state <= IDLE;
      endcase
      if (load) begin
        state <= RUN;
        if (hold_full) begin
          shreg <= left_slot[SLOT_W-1:0];
          right_reg <= hold_r;
          hold_full <= 1'b0;
        end else begin
          shreg <= '0;
          right_reg <= '0;
          underrun <= 1'b1;
          underrun_cnt <= &underrun_cnt ? underrun_cnt : underrun_cnt + CNT_W'(1);
        end
      end
    end
  end
endmodule

// File: tb/tb_i2s_tx_ctrl.sv
// tb_i2s_tx_ctrl: scoreboard bench for i2s_tx_ctrl with a bclk = adc_clk/4, 32-bit slot clock model
module tb_i2s_tx_ctrl;
  localparam int DW = 24;
  localparam int SW = 32;
  logic adc_clk = 1'b0;
  logic adc_rst_n = 1'b0;
  logic enable = 1'b0;
  logic enable2 = 1'b0;
  logic [7:0] gen = 8'd0;
  logic i2s_bclk;
  logic i2s_wclk;
  logic sdata;
  logic busy;
  logic underrun;
  logic [15:0] cnt;
  logic sdata2;
  logic busy2;
  logic underrun2;
  logic [1:0] cnt2;
  int n_vec = 0;
  int n_err = 0;
  logic q[$];
  logic [23:0] lt[10] = '{24'h800000, 24'h7FFFFF, 24'h000001, 24'hFFFFFF, 24'h5A5A5A,
                          24'hA5A5A5, 24'h123456, 24'h0F0F0F, 24'hC00003, 24'h13579B};
  logic [23:0] rt[10] = '{24'h000001, 24'h800000, 24'hFEDCBA, 24'h000000, 24'hA5A5A5,
                          24'h5A5A5A, 24'h654321, 24'hF0F0F0, 24'h300006, 24'h2468AC};
  i2s_tx_ctrl_if #(.DATA_W(DW)) sif ();
  i2s_tx_ctrl_if #(.DATA_W(DW)) sif2 ();
  // one frame = 256 adc_clk: bclk = gen[1] (fall every 4 clocks), wclk = gen[7] switching on a bclk fall
  assign i2s_bclk = gen[1];
  assign i2s_wclk = gen[7];
  i2s_tx_ctrl #(.DATA_W(DW), .SLOT_W(SW), .CNT_W(16)) dut (
    .adc_clk(adc_clk), .adc_rst_n(adc_rst_n), .i2s_bclk(i2s_bclk), .i2s_wclk(i2s_wclk),
    .enable(enable), .s(sif.slave), .i2s_sdata(sdata), .busy(busy), .underrun(underrun),
    .underrun_cnt(cnt)
  );
  i2s_tx_ctrl #(.DATA_W(DW), .SLOT_W(SW), .CNT_W(2)) dut2 (
    .adc_clk(adc_clk), .adc_rst_n(adc_rst_n), .i2s_bclk(i2s_bclk), .i2s_wclk(i2s_wclk),
    .enable(enable2), .s(sif2.slave), .i2s_sdata(sdata2), .busy(busy2), .underrun(underrun2),
    .underrun_cnt(cnt2)
  );
  always #5 adc_clk = ~adc_clk;
  always @(negedge adc_clk) gen = gen + 8'd1;
  always begin : mon
    logic [7:0] g;
    logic e;
    @(posedge adc_clk);
    g = gen;
    #1;
    if (g[1:0] == 2'b00 && q.size() != 0) begin
      e = q.pop_front();
      n_vec++;
      if (sdata !== e) begin
        n_err++;
        $display("FAIL sdata bit at gen=%0d: got %b expected %b", g, sdata, e);
      end
    end
  end
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    n_vec++;
    if (act !== want) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, want);
    end
  endtask
  task automatic at_g(input logic [7:0] v);
    for (int i = 0; i < 600; i++) begin
      @(posedge adc_clk);
      #2;
      if (gen == v) return;
    end
    n_vec++;
    n_err++;
    $display("FAIL timeout waiting for gen=%0d", v);
  endtask
  task automatic push_frame(input logic [23:0] l, input logic [23:0] r);
    logic [63:0] f;
    f = {l, 8'h00, r, 8'h00};
    for (int i = 63; i >= 0; i--) q.push_back(f[i]);
  endtask
  task automatic offer(input logic [23:0] l, input logic [23:0] r);
    sif.s_left = l;
    sif.s_right = r;
    sif.s_valid = 1'b1;
    @(posedge adc_clk);
    #2;
    sif.s_valid = 1'b0;
  endtask
  initial begin
    sif.s_valid = 1'b0;
    sif.s_left = '0;
    sif.s_right = '0;
    sif2.s_valid = 1'b0;
    sif2.s_left = '0;
    sif2.s_right = '0;
    repeat (3) @(posedge adc_clk);
    #2;
    chk("reset sdata", 32'(sdata), 0);
    chk("reset s_ready", 32'(sif.s_ready), 1);
    chk("reset busy", 32'(busy), 0);
    chk("reset underrun", 32'(underrun), 0);
    chk("reset underrun_cnt", 32'(cnt), 0);
    at_g(8'd40);
    adc_rst_n = 1'b1;
    offer(24'hABCDEF, 24'h123456);
    chk("ready low after accept", 32'(sif.s_ready), 0);
    enable = 1'b1;
    enable2 = 1'b1;
    @(posedge adc_clk);
    #2;
    chk("busy in sync", 32'(busy), 1);
    at_g(8'd0);
    push_frame(24'hABCDEF, 24'h123456);
    chk("first frame no underrun", 32'(underrun), 0);
    chk("ready after first load", 32'(sif.s_ready), 1);
    chk("cnt2 first underrun", 32'(cnt2), 1);
    chk("underrun2 pulse", 32'(underrun2), 1);
    at_g(8'd0);
    push_frame(24'h0, 24'h0);
    chk("empty frame underrun", 32'(underrun), 1);
    chk("empty frame cnt", 32'(cnt), 1);
    at_g(8'd64);
    offer(24'h3C3C3C, 24'hC3C3C3);
    chk("mid-frame accept ready", 32'(sif.s_ready), 0);
    at_g(8'd0);
    push_frame(24'h3C3C3C, 24'hC3C3C3);
    chk("held frame no underrun", 32'(underrun), 0);
    chk("held frame cnt stays", 32'(cnt), 1);
    at_g(8'd255);
    sif.s_left = 24'h9ABCDE;
    sif.s_right = 24'h0FEDCB;
    sif.s_valid = 1'b1;
    at_g(8'd0);
    sif.s_valid = 1'b0;
    push_frame(24'h0, 24'h0);
    chk("accept at wfall underruns", 32'(underrun), 1);
    chk("accept at wfall cnt", 32'(cnt), 2);
    chk("accept at wfall held", 32'(sif.s_ready), 0);
    at_g(8'd0);
    push_frame(24'h9ABCDE, 24'h0FEDCB);
    chk("late pair plays", 32'(underrun), 0);
    chk("late pair drained", 32'(sif.s_ready), 1);
    for (int k = 0; k < 10; k++) begin
      at_g(8'd64);
      offer(lt[k], rt[k]);
      chk("stream ready drops", 32'(sif.s_ready), 0);
      at_g(8'd0);
      push_frame(lt[k], rt[k]);
      chk("stream no underrun", 32'(underrun), 0);
      chk("stream ready rises", 32'(sif.s_ready), 1);
      chk("stream cnt", 32'(cnt), 2);
      chk("cnt2 saturated", 32'(cnt2), 3);
    end
    at_g(8'd40);
    enable = 1'b0;
    at_g(8'd0);
    chk("stop no underrun", 32'(underrun), 0);
    chk("stop busy", 32'(busy), 0);
    chk("stop sdata", 32'(sdata), 0);
    chk("stop cnt", 32'(cnt), 2);
    offer(24'hFFFFFF, 24'h000001);
    chk("accept while idle", 32'(sif.s_ready), 0);
    at_g(8'd100);
    chk("idle sdata", 32'(sdata), 0);
    enable = 1'b1;
    @(posedge adc_clk);
    #2;
    chk("re-enable busy", 32'(busy), 1);
    at_g(8'd0);
    push_frame(24'hFFFFFF, 24'h000001);
    chk("realign no underrun", 32'(underrun), 0);
    chk("realign drained", 32'(sif.s_ready), 1);
    at_g(8'd20);
    chk("sdata high before reset", 32'(sdata), 1);
    q.delete();
    adc_rst_n = 1'b0;
    #1;
    chk("async reset sdata", 32'(sdata), 0);
    chk("async reset busy", 32'(busy), 0);
    chk("async reset ready", 32'(sif.s_ready), 1);
    chk("async reset underrun", 32'(underrun), 0);
    chk("async reset cnt", 32'(cnt), 0);
    chk("async reset cnt2", 32'(cnt2), 0);
    at_g(8'd30);
    adc_rst_n = 1'b1;
    offer(24'hA5A5A5, 24'h5A5A5A);
    at_g(8'd0);
    push_frame(24'hA5A5A5, 24'h5A5A5A);
    chk("post-reset frame no underrun", 32'(underrun), 0);
    chk("post-reset cnt", 32'(cnt), 0);
    at_g(8'd0);
    chk("post-reset underrun", 32'(underrun), 1);
    chk("post-reset cnt one", 32'(cnt), 1);
    chk("scoreboard drained", 32'(q.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
